mux_sequencer: RTL
==================

# mux_sequencer

Parametrised, registered N-channel multiplexer for the lab datapath. It extends the fixed 8:1 strobed multiplexer with configurable channel count and data width. It adds three sequenced modes: continuous auto-scan, single-shot sweep with completion pulse, and output hold. It sits between parallel channel sources and a single downstream consumer such as a display, LED bank or serial shifter.

## Interface
- N_CH, default 8: number of input channels, 2 to 256.
- W, default 1: data bits per channel, 1 to 32.
- DWELL, default 4: cycles each channel is presented in scan/sweep modes, 1 to 65535.
- SW (localparam): $clog2(N_CH).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  strobe, active-high; low forces f=0, valid=0 and freezes all counters and state.
- mode  input  2  00 direct, 01 scan, 10 sweep, 11 hold.
- sel  input  SW  channel select, used in direct mode only.
- start  input  1  one-cycle pulse that launches a sweep.
- d  input  N_CH*W  channel data; channel k occupies d[k*W +: W].
- f  output  W  registered selected data.
- ch  output  SW  channel index currently driven on f.
- valid  output  1  f carries a sampled channel.
- done  output  1  one-cycle pulse at end of sweep.

## Operation
- FSM states: DIRECT, SCAN, SWEEP_IDLE, SWEEP_RUN, HOLD. Internal state is a channel counter (SW bits) and a dwell counter (16 bits).
- Each active edge (en=1) picks channel c and registers f<=d[c], ch<=c. f and ch always change on the same edge.
- mode is sampled every active edge. A mode change moves the FSM on that edge:
  - 00 -> DIRECT.
  - 01 -> SCAN, with channel and dwell counters cleared.
  - 10 -> SWEEP_IDLE.
  - 11 -> HOLD.
- DIRECT: c=sel, valid<=1. If sel>=N_CH then f<=0, ch<=sel, valid<=0.
- SCAN: c=channel counter, valid<=1. Dwell counter increments each edge. At DWELL-1 it clears and the channel counter advances, wrapping N_CH-1 -> 0.
- SWEEP_IDLE: f<=0, valid<=0, counters cleared. start=1 -> SWEEP_RUN.
- SWEEP_RUN: stepping as in SCAN, starting at channel 0, valid<=1. start is ignored.
  - When channel N_CH-1 finishes its dwell: -> SWEEP_IDLE, done<=1 for exactly one cycle, f<=0, valid<=0.
  - Changing mode away from 10 aborts the sweep without done.
- HOLD: f, ch, valid frozen; counters frozen. Returning to mode 01 restarts the scan at channel 0.
- en=0: f<=0, valid<=0, done<=0. ch, counters and FSM state are unchanged. The mode input is ignored. Resuming continues exactly where the sequence stopped.
- rst=1 at any time, including mid-sweep: state DIRECT, f=0, ch=0, valid=0, done=0, counters 0. No done pulse for an aborted sweep.

## Timing
- Latency: d/sel to f is 1 cycle (registered). No combinational path from inputs to outputs.
- Reset values: f=0, ch=0, valid=0, done=0. First output follows the first active edge after rst deasserts.
- Scan/sweep: each channel appears on ch for exactly DWELL consecutive active cycles. A scan period is N_CH*DWELL cycles.
- Sweep: start accepted on edge t gives ch=0 valid from edge t+1. The last channel is presented through edge t+N_CH*DWELL. done=1 and valid=0 at edge t+N_CH*DWELL+1.
- Dwell and channel counters advance only on active edges (en=1). Stalled cycles do not count.
- start and mode change on the same edge while in SWEEP_IDLE: the mode change wins and start is dropped.

## Test plan
- Direct, N_CH=8, W=4, d[k]=k+3, sel swept 0..7 -> f=3..10 one cycle after each sel, ch=sel, valid=1.
- Out-of-range, N_CH=6, sel=7 -> f=0, valid=0, ch=7. Then sel=5 -> f=d[5], valid=1.
- Scan, N_CH=4, DWELL=2 -> ch sequence 0,0,1,1,2,2,3,3,0,0 with f tracking d[ch]. Mid-run, en=0 for 3 cycles -> f=0, valid=0. On resume the sequence continues from the stall point with no skipped or repeated dwell.
- Sweep, N_CH=4, DWELL=3, start at edge t -> valid for edges t+1..t+12, done=1 only at t+13. A second start during the run is ignored. start in SWEEP_IDLE relaunches.
- Hold: scan to ch=2, then mode=11 for 5 cycles -> f, ch, valid constant. mode=01 -> scan restarts at ch=0.
- Async reset asserted mid-sweep, between clock edges -> outputs zero immediately with no done pulse. After release with mode=00 -> direct operation on the next edge.

Source files
------------

// File: rtl/mux_sequencer_if.sv
// rtl/mux_sequencer_if.sv - channel, control and result bus of mux_sequencer
interface mux_sequencer_if #(
  parameter int N_CH = 8,
  parameter int W    = 1
) ();
  localparam int SW = $clog2(N_CH);

  logic              en;
  logic [1:0]        mode;
  logic [SW-1:0]     sel;
  logic              start;
  logic [N_CH*W-1:0] d;
  logic [W-1:0]      f;
  logic [SW-1:0]     ch;
  logic              valid;
  logic              done;

  modport master (output en, mode, sel, start, d, input f, ch, valid, done);
  modport slave  (input en, mode, sel, start, d, output f, ch, valid, done);
endinterface

// File: rtl/mux_sequencer.sv
// rtl/mux_sequencer.sv - registered N-channel mux with direct, scan, sweep and hold modes
module mux_sequencer #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input logic            clk,
  input logic            rst,
  mux_sequencer_if.slave bus
);
  localparam int              SW         = $clog2(N_CH);
  localparam logic [SW:0]     N_CH_X     = (SW+1)'(N_CH);
  localparam logic [SW-1:0]   LAST_CH    = SW'(N_CH - 1);
  // A sweep parks its dwell counter at DWELL after the last channel so the
  // following active edge knows to emit done.
  localparam logic [15:0]     DWELL_END  = 16'(DWELL);
  localparam logic [15:0]     DWELL_LAST = 16'(DWELL - 1);

  typedef enum logic [2:0] {
    S_DIRECT,
    S_SCAN,
    S_SWEEP_IDLE,
    S_SWEEP_RUN,
    S_HOLD
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] chan, chan_nxt;
  logic [15:0]   dwell, dwell_nxt;
  logic [W-1:0]  f_q, f_nxt;
  logic [SW-1:0] ch_q, ch_nxt;
  logic          valid_q, valid_nxt;
  logic          done_q, done_nxt;
  logic [SW-1:0] scan_c;
  logic [15:0]   scan_dw;

  logic [W-1:0]  d_arr [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_split
    assign d_arr[k] = bus.d[k*W +: W];
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_DIRECT;
    else     state <= state_nxt;
  end

  // Next state: mode picks the target on every active edge, en=0 freezes
  always_comb begin
    state_nxt = state;
    if (bus.en) begin
      case (bus.mode)
        2'b00: state_nxt = S_DIRECT;
        2'b01: state_nxt = S_SCAN;
        2'b10: begin
          case (state)
            S_SWEEP_IDLE: state_nxt = bus.start ? S_SWEEP_RUN : S_SWEEP_IDLE;
            S_SWEEP_RUN:  state_nxt = (dwell == DWELL_END) ? S_SWEEP_IDLE : S_SWEEP_RUN;
            default:      state_nxt = S_SWEEP_IDLE;
          endcase
        end
        default: state_nxt = S_HOLD;
      endcase
    end
  end

  // Output/counter next values; entering scan behaves as a scan edge with cleared counters
  always_comb begin
    f_nxt     = f_q;
    ch_nxt    = ch_q;
    valid_nxt = valid_q;
    done_nxt  = 1'b0;
    chan_nxt  = chan;
    dwell_nxt = dwell;
    scan_c    = (state == S_SCAN) ? chan  : '0;
    scan_dw   = (state == S_SCAN) ? dwell : '0;
    if (!bus.en) begin
      f_nxt     = '0;
      valid_nxt = 1'b0;
    end else begin
      case (bus.mode)
        2'b00: begin
          ch_nxt = bus.sel;
          if ({1'b0, bus.sel} < N_CH_X) begin
            f_nxt     = d_arr[bus.sel];
            valid_nxt = 1'b1;
          end else begin
            f_nxt     = '0;
            valid_nxt = 1'b0;
          end
        end
        2'b01: begin
          f_nxt     = d_arr[scan_c];
          ch_nxt    = scan_c;
          valid_nxt = 1'b1;
          if (scan_dw == DWELL_LAST) begin
            dwell_nxt = '0;
            chan_nxt  = (scan_c == LAST_CH) ? '0 : scan_c + SW'(1);
          end else begin
            dwell_nxt = scan_dw + 16'd1;
            chan_nxt  = scan_c;
          end
        end
        2'b10: begin
          if (state == S_SWEEP_RUN && dwell != DWELL_END) begin
            f_nxt     = d_arr[chan];
            ch_nxt    = chan;
            valid_nxt = 1'b1;
            if (dwell == DWELL_LAST) begin
              if (chan == LAST_CH) begin
                dwell_nxt = DWELL_END;
              end else begin
                dwell_nxt = '0;
                chan_nxt  = chan + SW'(1);
              end
            end else begin
              dwell_nxt = dwell + 16'd1;
            end
          end else begin
            f_nxt     = '0;
            valid_nxt = 1'b0;
            chan_nxt  = '0;
            dwell_nxt = '0;
            done_nxt  = (state == S_SWEEP_RUN);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      chan    <= '0;
      dwell   <= '0;
    end else begin
      f_q     <= f_nxt;
      ch_q    <= ch_nxt;
      valid_q <= valid_nxt;
      done_q  <= done_nxt;
      chan    <= chan_nxt;
      dwell   <= dwell_nxt;
    end
  end

  assign bus.f     = f_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
  assign bus.done  = done_q;
endmodule
